vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 The block SHALL have parameter HORIZONTAL_IMAGEM, default 320, meaning image width in pixels.
REQ-002 The block SHALL have parameter VERTICAL_IMAGEM, default 240, meaning image height in lines.
REQ-003 The block SHALL have port vga_clk  input  1  pixel clock; the single clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have ports x_pixel, y_pixel  input  10 each  VGA pixel position from the timing generator.
REQ-006 The block SHALL have ports data_enable, VGAHS_in, VGAVS_in  input  1 each  active area, HSYNC and VSYNC; both syncs are active-low.
REQ-007 The block SHALL have ports wr_start  input  1  arm a frame load.
REQ-008 The block SHALL have ports wr_valid  input  1 and wr_data  input  8 (RGB332), plus wr_ready  output  1  writer stream handshake.
REQ-009 The block SHALL have ports wr_busy  output  1 and wr_done  output  1  load in progress, and a one-cycle completion pulse.
REQ-010 The block SHALL have ports ram_addr  output  17, ram_we  output  1, ram_wdata  output  8 and ram_rdata  input  8  single-port framebuffer RAM with 1-cycle read latency.
REQ-011 The block SHALL have ports VGA_R, VGA_G, VGA_B  output  3 each, and VGAHS, VGAVS  output  1 each  display outputs.

Function
REQ-012 Display slot: a cycle SHALL be a display slot when data_enable=1 and x_pixel[0]=0; every other cycle is a free slot.
REQ-013 Display address SHALL be (y_pixel>>1)*HORIZONTAL_IMAGEM + (x_pixel>>1), computed with shifts and adds only ((y<<8)+(y<<6) at default width), 17 bits wide.
REQ-014 ram_addr, ram_we and ram_wdata SHALL be registered; a display slot in cycle N drives a read address in cycle N+1.
REQ-015 The pixel byte SHALL be captured from ram_rdata in cycle N+2 and held through the odd-x cycle (2x horizontal upscale).
REQ-016 VGA_R/G/B SHALL be registered in cycle N+3: R=byte[7:5], G=byte[4:2], B mapped 00->000, 01->011, 10->101, 11->111; outputs SHALL be 0 when the 3-stage delayed data_enable is 0.
REQ-017 VGAHS and VGAVS SHALL be delayed by exactly 3 registers, so total latency from inputs to all display outputs is 3 cycles.
REQ-018 The writer FSM SHALL have states IDLE, WAIT_VBLANK and STREAM.
REQ-019 IDLE -> WAIT_VBLANK on wr_start=1, with the write counter cleared to 0.
REQ-020 WAIT_VBLANK -> STREAM on the VGAVS_in falling edge (start of VSYNC).
REQ-021 In STREAM, wr_ready SHALL be 1 only in free slots, and is combinational from state and current x_pixel/data_enable.
REQ-022 A transfer SHALL occur when wr_valid and wr_ready are both 1; the next cycle drives ram_we=1, ram_addr=counter, ram_wdata=wr_data, and the counter increments.
REQ-023 The transfer with counter = HORIZONTAL_IMAGEM*VERTICAL_IMAGEM-1 SHALL return the FSM to IDLE and pulse wr_done for one cycle; the counter never wraps mid-load.
REQ-024 wr_busy SHALL be 1 in WAIT_VBLANK and STREAM.
REQ-025 wr_start SHALL be ignored while not in IDLE, including when asserted in the same cycle as the final transfer.
REQ-026 The writer SHALL never drive ram_we in a cycle that carries a display read, so display reads are never delayed.
REQ-027 wr_ready SHALL be 0 in IDLE and WAIT_VBLANK.

Reset
REQ-028 Reset SHALL set: FSM IDLE; counter 0; VGA_R/G/B=0; VGAHS=VGAVS=1 along with all sync delay stages; ram_we=0, ram_addr=0, ram_wdata=0; wr_ready=0, wr_busy=0, wr_done=0; pixel hold register 0.
REQ-029 Reset mid-load SHALL abort the load without a wr_done pulse; the partial frame remains in RAM.

Structure
REQ-030 Image dimensions, pixel count (76800), address width (17) and FSM state encodings SHALL reside in a shared package vga_pkg.
REQ-031 The RGB332-to-3-3-3 output stage and its sync delays SHALL form one sub-module, vga_rgb332_out; the RAM itself is external.

Verification
REQ-032 Reset then idle frame with RAM preloaded addr=data[7:0]: pixel (x=2,y=2) -> address 321; output appears 3 cycles later and is repeated at x=3.
REQ-033 wr_start, wr_valid held 1 -> no write before the VSYNC falling edge; exactly 76800 writes with addresses 0..76799; wr_done pulses once; FSM returns to IDLE.
REQ-034 Active line during STREAM -> ram_we=1 never coincides with a read cycle; wr_ready=0 on every even-x active cycle.
REQ-035 Byte 0x03 in RAM -> VGA_B=111 and VGA_R=VGA_G=000; byte 0xE1 -> R=111, G=000, B=011.
REQ-036 rst asserted at counter=1000 -> next cycle wr_busy=0, ram_we=0, and no wr_done pulse; a later wr_start restarts the load at address 0.
REQ-037 wr_start during STREAM and in the final-transfer cycle -> ignored; FSM in IDLE afterwards.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared framebuffer geometry, writer FSM encoding and the RGB332 blue-channel expansion.
package vga_pkg;
  localparam int H_IMG   = 320;
  localparam int V_IMG   = 240;
  localparam int PIX_CNT = H_IMG * V_IMG;
  localparam int ADDR_W  = 17;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_VBLANK = 2'd1,
    ST_STREAM      = 2'd2
  } wr_state_t;

  // 2-bit blue spread over 3 bits so full-scale stays full-scale
  function automatic logic [2:0] b2_to_b3(input logic [1:0] b);
    case (b)
      2'b00:   return 3'b000;
      2'b01:   return 3'b011;
      2'b10:   return 3'b101;
      default: return 3'b111;
    endcase
  endfunction
endpackage

// File: rtl/vga_rgb332_out.sv
// Display back end: captures the RAM byte, holds it for the odd pixel, expands RGB332 and
// delays the syncs so colour and sync leave together three cycles after the timing inputs.
module vga_rgb332_out
  import vga_pkg::*;
(
  input  logic       vga_clk,
  input  logic       rst,
  input  logic       i_de,
  input  logic       i_slot,
  input  logic       i_hs,
  input  logic       i_vs,
  input  logic [7:0] i_rdata,
  output logic [2:0] o_r,
  output logic [2:0] o_g,
  output logic [2:0] o_b,
  output logic       o_hs,
  output logic       o_vs
);
  logic [3:1] r_hs_pipe, r_vs_pipe;
  logic [2:1] r_de_pipe, r_slot_pipe;
  logic [7:0] r_pix;
  logic [7:0] w_pix;

  // RAM data is only meaningful two cycles after a read slot; otherwise replay the held byte
  assign w_pix = r_slot_pipe[2] ? i_rdata : r_pix;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_hs_pipe   <= '1;
      r_vs_pipe   <= '1;
      r_de_pipe   <= '0;
      r_slot_pipe <= '0;
      r_pix       <= '0;
      o_r         <= '0;
      o_g         <= '0;
      o_b         <= '0;
    end else begin
      r_hs_pipe   <= {r_hs_pipe[2:1], i_hs};
      r_vs_pipe   <= {r_vs_pipe[2:1], i_vs};
      r_de_pipe   <= {r_de_pipe[1], i_de};
      r_slot_pipe <= {r_slot_pipe[1], i_slot};
      if (r_slot_pipe[2]) r_pix <= i_rdata;
      if (r_de_pipe[2]) begin
        o_r <= w_pix[7:5];
        o_g <= w_pix[4:2];
        o_b <= b2_to_b3(w_pix[1:0]);
      end else begin
        o_r <= '0;
        o_g <= '0;
        o_b <= '0;
      end
    end
  end

  assign o_hs = r_hs_pipe[3];
  assign o_vs = r_vs_pipe[3];
endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between 2x-upscaled VGA scan-out (even-x active
// cycles) and a frame writer that streams a full image into the remaining free cycles.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int HORIZONTAL_IMAGEM = H_IMG,
  parameter int VERTICAL_IMAGEM   = V_IMG
) (
  input  logic              vga_clk,
  input  logic              rst,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  input  logic              data_enable,
  input  logic              VGAHS_in,
  input  logic              VGAVS_in,
  input  logic              wr_start,
  input  logic              wr_valid,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  output logic              wr_busy,
  output logic              wr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [2:0]        VGA_R,
  output logic [2:0]        VGA_G,
  output logic [2:0]        VGA_B,
  output logic              VGAHS,
  output logic              VGAVS
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(HORIZONTAL_IMAGEM * VERTICAL_IMAGEM - 1);

  wr_state_t         r_state;
  logic [ADDR_W-1:0] r_cnt, r_ram_addr;
  logic              r_ram_we, r_done, r_vs_prev;
  logic [7:0]        r_ram_wdata;
  logic              w_slot, w_vs_fall, w_ready, w_xfer;
  logic [ADDR_W-1:0] w_disp_addr;
  logic              w_unused;

  assign w_unused  = y_pixel[0];
  assign w_slot    = data_enable & ~x_pixel[0];
  assign w_vs_fall = r_vs_prev & ~VGAVS_in;
  assign w_ready   = (r_state == ST_STREAM) & ~w_slot;
  assign w_xfer    = wr_valid & w_ready;

  // (y>>1)*width as a constant shift-add chain over the set bits of the width
  always_comb begin
    w_disp_addr = ADDR_W'(x_pixel[9:1]);
    for (int i = 0; i < ADDR_W; i++)
      if (HORIZONTAL_IMAGEM[i]) w_disp_addr = w_disp_addr + (ADDR_W'(y_pixel[9:1]) << i);
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_done      <= 1'b0;
      r_vs_prev   <= 1'b1;
    end else begin
      r_vs_prev <= VGAVS_in;
      r_ram_we  <= 1'b0;
      r_done    <= 1'b0;
      if (w_slot) r_ram_addr <= w_disp_addr;
      case (r_state)
        ST_IDLE: if (wr_start) begin
          r_cnt   <= '0;
          r_state <= ST_WAIT_VBLANK;
        end
        ST_WAIT_VBLANK: if (w_vs_fall) r_state <= ST_STREAM;
        ST_STREAM: if (w_xfer) begin
          // w_xfer excludes display slots, so this never collides with the read address above
          r_ram_we    <= 1'b1;
          r_ram_addr  <= r_cnt;
          r_ram_wdata <= wr_data;
          r_cnt       <= r_cnt + 1'b1;
          if (r_cnt == LAST_ADDR) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr_ready  = w_ready;
  assign wr_busy   = (r_state != ST_IDLE);
  assign wr_done   = r_done;
  assign ram_addr  = r_ram_addr;
  assign ram_we    = r_ram_we;
  assign ram_wdata = r_ram_wdata;

  vga_rgb332_out u_out (
    .vga_clk (vga_clk),
    .rst     (rst),
    .i_de    (data_enable),
    .i_slot  (w_slot),
    .i_hs    (VGAHS_in),
    .i_vs    (VGAVS_in),
    .i_rdata (ram_rdata),
    .o_r     (VGA_R),
    .o_g     (VGA_G),
    .o_b     (VGA_B),
    .o_hs    (VGAHS),
    .o_vs    (VGAVS)
  );
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: behavioural RAM, cycle reference model, vector table and load sequences.
module tb_vga_fb_arbiter;
  localparam int W    = 320;
  localparam int NPIX = 76800;

  logic        vga_clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  x_pixel = '0, y_pixel = '0;
  logic        data_enable = 1'b0, VGAHS_in = 1'b1, VGAVS_in = 1'b1;
  logic        wr_start = 1'b0, wr_valid = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_ready, wr_busy, wr_done, ram_we;
  logic [16:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic [2:0]  VGA_R, VGA_G, VGA_B;
  logic        VGAHS, VGAVS;

  always #5 vga_clk = ~vga_clk;

  vga_fb_arbiter dut (
    .vga_clk(vga_clk), .rst(rst), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .data_enable(data_enable), .VGAHS_in(VGAHS_in), .VGAVS_in(VGAVS_in),
    .wr_start(wr_start), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .wr_busy(wr_busy), .wr_done(wr_done), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B), .VGAHS(VGAHS), .VGAVS(VGAVS)
  );

  // Single-port RAM, 1-cycle read latency, read-before-write; bench preload/poke port
  logic [7:0]  ram [0:131071];
  logic        ram_init = 1'b0, tb_we = 1'b0;
  logic [16:0] tb_addr = '0;
  logic [7:0]  tb_data = '0;
  always @(posedge vga_clk) begin
    if (ram_init) for (int i = 0; i < 131072; i++) ram[i] <= 8'(i);
    else if (tb_we) ram[tb_addr] <= tb_data;
    else if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  int n_err = 0, n_chk = 0;
  int n_wr = 0, n_done = 0;
  logic [16:0] last_wr_addr = '1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] blue3(input logic [1:0] b);
    logic [2:0] lut [4];
    lut[0] = 3'd0; lut[1] = 3'd3; lut[2] = 3'd5; lut[3] = 3'd7;
    return lut[b];
  endfunction

  // Reference model: per-cycle input history and the writer's mode as plain flags
  typedef struct {
    logic de, hs, vs, slot;
    logic [16:0] addr;
    logic [7:0]  byt;
  } hist_t;
  hist_t h [0:3];
  hist_t rst_e;
  logic  m_wait = 1'b0, m_stream = 1'b0, m_vs_prev = 1'b1;
  int    m_cnt = 0;

  // One clock cycle: inputs already set by the caller at the previous negedge.
  task automatic tick();
    hist_t e;
    logic  pend, exp_done;
    logic [16:0] p_addr;
    logic [7:0]  p_data, eb;
    logic [8:0]  exp_rgb;
    #1;
    e.de   = data_enable;
    e.hs   = VGAHS_in;
    e.vs   = VGAVS_in;
    e.slot = data_enable && !x_pixel[0];
    e.addr = 17'((int'(y_pixel) / 2) * W + int'(x_pixel) / 2);
    e.byt  = ram[e.addr];
    chk("wr_ready", wr_ready, m_stream && !e.slot);
    chk("wr_busy", wr_busy, m_wait || m_stream);
    pend = 1'b0; exp_done = 1'b0; p_addr = '0; p_data = '0;
    if (rst) begin
      m_wait = 1'b0; m_stream = 1'b0; m_cnt = 0;
      e = rst_e;
      for (int i = 0; i < 4; i++) h[i] = rst_e;
    end else if (!m_wait && !m_stream) begin
      if (wr_start) begin m_wait = 1'b1; m_cnt = 0; end
    end else if (m_wait) begin
      if (m_vs_prev && !VGAVS_in) begin m_wait = 1'b0; m_stream = 1'b1; end
    end else if (wr_valid && !e.slot) begin
      pend = 1'b1; p_addr = 17'(m_cnt); p_data = wr_data;
      if (m_cnt == NPIX - 1) begin m_stream = 1'b0; exp_done = 1'b1; end
      m_cnt++;
    end
    m_vs_prev = rst ? 1'b1 : VGAVS_in;
    h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = e;
    @(posedge vga_clk);
    @(negedge vga_clk);
    chk("ram_we", ram_we, pend);
    chk("we_on_read", ram_we & h[0].slot, 0);
    if (ram_we) begin n_wr++; last_wr_addr = ram_addr; end
    if (pend) begin
      chk("wr_addr", ram_addr, p_addr);
      chk("wr_data", ram_wdata, p_data);
    end else if (h[0].slot) chk("rd_addr", ram_addr, h[0].addr);
    chk("wr_done", wr_done, exp_done);
    if (wr_done) n_done++;
    eb = h[2].byt;
    exp_rgb = h[2].de ? {eb[7:5], eb[4:2], blue3(eb[1:0])} : 9'd0;
    chk("rgb", {VGA_R, VGA_G, VGA_B}, exp_rgb);
    chk("hs", VGAHS, h[2].hs);
    chk("vs", VGAVS, h[2].vs);
  endtask

  typedef struct {
    int x, y;
    logic [16:0] addr;
    logic [7:0]  byt;
    logic [2:0]  r, g, b;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int guard, d0;
    rst_e = '{de: 1'b0, hs: 1'b1, vs: 1'b1, slot: 1'b0, addr: 17'd0, byt: 8'd0};
    for (int i = 0; i < 4; i++) h[i] = rst_e;
    tbl[0] = '{2,   2,   17'd321,   8'h41, 3'd2, 3'd0, 3'd3};
    tbl[1] = '{10,  4,   17'd645,   8'h03, 3'd0, 3'd0, 3'd7};
    tbl[2] = '{100, 7,   17'd1010,  8'hE1, 3'd7, 3'd0, 3'd3};
    tbl[3] = '{0,   0,   17'd0,     8'hFF, 3'd7, 3'd7, 3'd7};
    tbl[4] = '{638, 478, 17'd76799, 8'h96, 3'd4, 3'd5, 3'd5};
    tbl[5] = '{320, 240, 17'd38560, 8'h00, 3'd0, 3'd0, 3'd0};

    // Reset with RAM preload addr -> addr[7:0]
    ram_init = 1'b1;
    @(posedge vga_clk); #1 ram_init = 1'b0;
    @(posedge vga_clk);
    @(negedge vga_clk);
    chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    chk("rst_hs", VGAHS, 1);
    chk("rst_vs", VGAVS, 1);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_ready", wr_ready, 0);
    chk("rst_busy", wr_busy, 0);
    chk("rst_done", wr_done, 0);
    rst = 1'b0;
    repeat (4) tick();

    // Vector table: poke a byte, read it through an even/odd pixel pair
    foreach (tbl[k]) begin
      tb_we = 1'b1; tb_addr = tbl[k].addr; tb_data = tbl[k].byt;
      tick();
      tb_we = 1'b0;
      x_pixel = 10'(tbl[k].x); y_pixel = 10'(tbl[k].y); data_enable = 1'b1;
      tick();
      chk("tbl_addr", ram_addr, tbl[k].addr);
      x_pixel = 10'(tbl[k].x + 1);
      tick();
      data_enable = 1'b0;
      tick();
      chk("tbl_rgb_even", {VGA_R, VGA_G, VGA_B}, {tbl[k].r, tbl[k].g, tbl[k].b});
      tick();
      chk("tbl_rgb_odd", {VGA_R, VGA_G, VGA_B}, {tbl[k].r, tbl[k].g, tbl[k].b});
      tick();
      chk("tbl_rgb_blank", {VGA_R, VGA_G, VGA_B}, 0);
    end

    // Random active bursts with random syncs against the model
    for (int b = 0; b < 150; b++) begin
      int x0, len;
      x0 = 2 * $urandom_range(0, 300);
      len = 2 * $urandom_range(1, 10);
      y_pixel = 10'($urandom_range(0, 479));
      for (int i = 0; i < len; i++) begin
        x_pixel = 10'(x0 + i); data_enable = 1'b1;
        VGAHS_in = 1'($urandom); VGAVS_in = 1'($urandom);
        tick();
      end
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
        x_pixel = 10'($urandom); data_enable = 1'b0;
        VGAHS_in = 1'($urandom); VGAVS_in = 1'($urandom);
        tick();
      end
    end
    VGAHS_in = 1'b1; VGAVS_in = 1'b1;
    tick();

    // Full frame load: armed early, nothing written until the VSYNC falling edge
    n_wr = 0; n_done = 0;
    wr_valid = 1'b1; wr_data = 8'($urandom); wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    repeat (20) begin wr_data = 8'($urandom); tick(); end
    chk("no_wr_before_vs", n_wr, 0);
    chk("busy_waiting", wr_busy, 1);
    VGAVS_in = 1'b0;
    repeat (3) tick();
    VGAVS_in = 1'b1;
    // one active line while streaming; display rows far from the low write addresses
    y_pixel = 10'd200;
    for (int x = 0; x < 640; x++) begin
      x_pixel = 10'(x); data_enable = 1'b1;
      wr_valid = ($urandom_range(0, 3) != 0); wr_data = 8'($urandom);
      wr_start = ($urandom_range(0, 15) == 0);
      #1;
      if (!x[0]) chk("even_x_ready", wr_ready, 0);
      tick();
    end
    data_enable = 1'b0; wr_valid = 1'b1;
    guard = 0;
    while (n_done == 0 && guard < 80000) begin
      x_pixel = 10'($urandom); wr_data = 8'($urandom);
      wr_start = m_stream && (m_cnt >= NPIX - 8);
      tick();
      guard++;
    end
    wr_start = 1'b0; wr_valid = 1'b0;
    chk("done_seen", n_done, 1);
    chk("n_writes", n_wr, NPIX);
    chk("last_addr", last_wr_addr, NPIX - 1);
    repeat (6) tick();
    chk("idle_after_load", wr_busy, 0);
    chk("single_done", n_done, 1);

    // Reset at counter 1000 aborts the load, then a restart begins at address 0
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    tick();
    VGAVS_in = 1'b0; tick(); VGAVS_in = 1'b1;
    wr_valid = 1'b1;
    guard = 0;
    while (m_cnt < 1000 && guard < 3000) begin wr_data = 8'($urandom); tick(); guard++; end
    chk("cnt_reached", m_cnt, 1000);
    d0 = n_done;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", wr_busy, 0);
    chk("abort_we", ram_we, 0);
    repeat (5) tick();
    chk("abort_no_done", n_done, d0);
    n_wr = 0;
    wr_start = 1'b1; tick(); wr_start = 1'b0;
    tick();
    VGAVS_in = 1'b0; tick(); VGAVS_in = 1'b1;
    wr_data = 8'h5A;
    tick();
    chk("restart_writes", n_wr, 1);
    chk("restart_addr", last_wr_addr, 0);
    wr_valid = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
